// File: rtl/muldiv_hilo.sv
// Iterative signed MULT/DIV unit that owns the HI/LO registers.
// Serves MFHI/MFLO and stalls the pipeline on HI/LO instructions while an op runs.
//
// state  | meaning
// S_IDLE | waiting; MULT/DIV accepted here, MFHI/MFLO served combinationally
// S_MUL  | one shift-add step per cycle on the magnitude product
// S_DIV  | one restoring shift-subtract step per cycle on {rem, quo}
// S_FIX  | apply sign correction and write HI/LO
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [3:0]       i_alucontrol,
  input  logic             i_hien,
  input  logic             i_loen,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_mfresult,
  output logic             o_busy,
  output logic             o_stall
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_is_div;
  logic               r_negp;
  logic               r_negr;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_is_muldiv;
  logic               w_is_hilo;
  logic               w_accept;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_acc_hi;
  logic [WIDTH-1:0]   w_acc_lo;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_is_muldiv = (i_alucontrol == OP_MULT) || (i_alucontrol == OP_DIV);
  assign w_is_hilo   = w_is_muldiv || (i_alucontrol == OP_MFHI) || (i_alucontrol == OP_MFLO);
  assign w_accept    = (r_state == S_IDLE) && i_start && i_hien && i_loen && w_is_muldiv;

  // Negating the most negative value yields itself, which is exactly 2^(WIDTH-1) unsigned.
  assign w_abs_a = i_srca[WIDTH-1] ? -i_srca : i_srca;
  assign w_abs_b = i_srcb[WIDTH-1] ? -i_srcb : i_srcb;

  assign w_acc_hi = r_acc[2*WIDTH-1:WIDTH];
  assign w_acc_lo = r_acc[WIDTH-1:0];

  // Multiplier bits sit in the low half and are consumed LSB first as the product shifts in.
  assign w_mul_sum  = {1'b0, w_acc_hi} + {1'b0, r_opb};
  assign w_mul_next = w_acc_lo[0] ? {w_mul_sum, w_acc_lo[WIDTH-1:1]}
                                  : {1'b0, w_acc_hi, w_acc_lo[WIDTH-1:1]};

  assign w_div_shift = {w_acc_hi, w_acc_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_next  = w_div_ge ? {w_div_diff[WIDTH-1:0],  w_acc_lo[WIDTH-2:0], 1'b1}
                                : {w_div_shift[WIDTH-1:0], w_acc_lo[WIDTH-2:0], 1'b0};

  assign w_prod_fix = r_negp ? -r_acc : r_acc;
  assign w_quo_fix  = r_negp ? -w_acc_lo : w_acc_lo;
  assign w_rem_fix  = r_negr ? -w_acc_hi : w_acc_hi;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_is_div <= 1'b0;
      r_negp   <= 1'b0;
      r_negr   <= 1'b0;
      r_count  <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div <= (i_alucontrol == OP_DIV);
            r_negp   <= i_srca[WIDTH-1] ^ i_srcb[WIDTH-1];
            r_negr   <= i_srca[WIDTH-1];
            r_count  <= '0;
            if (i_alucontrol == OP_DIV) begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
              r_opb   <= w_abs_b;
              r_state <= S_DIV;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
              r_opb   <= w_abs_a;
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          r_acc   <= w_mul_next;
          r_count <= r_count + CW'(1);
          if (r_count == LAST) r_state <= S_FIX;
        end
        S_DIV: begin
          r_acc   <= w_div_next;
          r_count <= r_count + CW'(1);
          if (r_count == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_mfresult = '0;
    if (i_alucontrol == OP_MFHI)      o_mfresult = r_hi;
    else if (i_alucontrol == OP_MFLO) o_mfresult = r_lo;
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_busy  = (r_state != S_IDLE);
  assign o_stall = o_busy && i_start && w_is_hilo;

endmodule
